// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and default widths for the writeback port arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default data / register address widths
//   wb_entry_t              : pending MDU result layout {rd, data, kill} at the
//                             default widths (the FIFO declares the same layout
//                             at its own parameter widths)
//   gnt_e                   : write-port grant decision for the current cycle
// -----------------------------------------------------------------------------
package wb_arb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] rd;
      logic [DATA_W_DEF-1:0] data;
      logic                  kill;
   } wb_entry_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_MDU  = 2'd2
   } gnt_e;

endpackage

// File: rtl/wb_pend_fifo.sv
// -----------------------------------------------------------------------------
// wb_pend_fifo
// DEPTH-entry circular buffer of pending MDU results. Every stored entry whose
// rd matches i_kill_rd is marked killed when i_kill_en is high.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_push, i_push_rd/data/kill : write a new entry at the tail
//   i_pop                     : drop the head entry (caller guarantees nonempty)
//   i_kill_en, i_kill_rd      : parallel rd-match kill of buffered entries
//   o_head_rd/data/kill       : head entry contents
//   o_cnt                     : occupied entries
// -----------------------------------------------------------------------------
module wb_pend_fifo
   import wb_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [ADDR_W-1:0]          i_push_rd,
   input  logic [DATA_W-1:0]          i_push_data,
   input  logic                       i_push_kill,
   input  logic                       i_pop,
   input  logic                       i_kill_en,
   input  logic [ADDR_W-1:0]          i_kill_rd,
   output logic [ADDR_W-1:0]          o_head_rd,
   output logic [DATA_W-1:0]          o_head_data,
   output logic                       o_head_kill,
   output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
      logic              kill;
   } ent_t;

   ent_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_cnt;
   ent_t             w_push_ent;

   // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_push_ent = '{rd: i_push_rd, data: i_push_data, kill: i_push_kill};

   // Kill marks may land on free slots too; a later push overwrites the whole
   // entry, so that is harmless. The push is written last so a same-cycle push
   // keeps the kill value the arbiter computed for it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_kill_en && (r_mem[i].rd == i_kill_rd)) r_mem[i].kill <= 1'b1;
         end
         if (i_push) r_mem[r_wptr] <= w_push_ent;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (i_push) r_wptr <= ptr_inc(r_wptr);
         if (i_pop)  r_rptr <= ptr_inc(r_rptr);
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head_rd   = r_mem[r_rptr].rd;
   assign o_head_data = r_mem[r_rptr].data;
   assign o_head_kill = r_mem[r_rptr].kill;
   assign o_cnt       = r_cnt;

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the in-order writeback
// stage (pipe) and the multi-cycle MDU. MDU results wait in a small pending
// buffer; a starvation counter forces an MDU slot after STARVE_LIMIT pipe
// grants, and a younger pipe write to the same rd kills stale MDU results.
//   clk, reset                 : clock, asynchronous active-low reset
//   pipe_valid/rd/data, pipe_ready : writeback request (hold while !pipe_ready)
//   mdu_valid/rd/data, mdu_ready   : MDU result push (ready = buffer not full)
//   rf_we, rf_waddr, rf_wdata  : registered register-file write
//   pend_cnt                   : occupied pending-buffer entries
// -----------------------------------------------------------------------------
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pipe_valid,
   input  logic [ADDR_W-1:0]          pipe_rd,
   input  logic [DATA_W-1:0]          pipe_data,
   output logic                       pipe_ready,
   input  logic                       mdu_valid,
   input  logic [ADDR_W-1:0]          mdu_rd,
   input  logic [DATA_W-1:0]          mdu_data,
   output logic                       mdu_ready,
   output logic                       rf_we,
   output logic [ADDR_W-1:0]          rf_waddr,
   output logic [DATA_W-1:0]          rf_wdata,
   output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int STV_W = $clog2(STARVE_LIMIT+1);

   logic [ADDR_W-1:0] w_head_rd;
   logic [DATA_W-1:0] w_head_data;
   logic              w_head_kill;
   logic [CNT_W-1:0]  w_cnt;
   logic              w_nonempty;
   logic              w_head_live;
   logic              w_force;
   logic              w_push;
   logic              w_pop;
   logic              w_kill_en;
   logic              w_push_kill;
   gnt_e              w_gnt;
   logic [ADDR_W-1:0] w_gnt_rd;
   logic [DATA_W-1:0] w_gnt_data;

   logic [STV_W-1:0]  r_starve;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;

   wb_pend_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .i_clk       (clk),
      .i_rst_n     (reset),
      .i_push      (w_push),
      .i_push_rd   (mdu_rd),
      .i_push_data (mdu_data),
      .i_push_kill (w_push_kill),
      .i_pop       (w_pop),
      .i_kill_en   (w_kill_en),
      .i_kill_rd   (pipe_rd),
      .o_head_rd   (w_head_rd),
      .o_head_data (w_head_data),
      .o_head_kill (w_head_kill),
      .o_cnt       (w_cnt)
   );

   assign w_nonempty  = (w_cnt != '0);
   assign w_head_live = w_nonempty && !w_head_kill;
   assign w_force     = w_head_live && (r_starve == STV_W'(STARVE_LIMIT));
   assign pipe_ready  = !w_force;

   // Ready comes from the registered count only: a full buffer never pushes,
   // even when the head leaves this same cycle.
   assign mdu_ready   = (w_cnt != CNT_W'(DEPTH));
   assign w_push      = mdu_valid && mdu_ready;

   always_comb begin
      w_gnt = GNT_NONE;
      if (pipe_valid && !w_force) w_gnt = GNT_PIPE;
      else if (w_head_live)       w_gnt = GNT_MDU;
   end

   // A killed head drains on its own without taking the port. Only entries
   // already stored can pop, so a push is never written in its own cycle.
   assign w_pop       = w_nonempty && (w_head_kill || (w_gnt == GNT_MDU));

   assign w_kill_en   = (w_gnt == GNT_PIPE) && (pipe_rd != '0);
   assign w_push_kill = w_kill_en && (mdu_rd == pipe_rd);

   always_comb begin
      w_gnt_rd   = '0;
      w_gnt_data = '0;
      case (w_gnt)
         GNT_PIPE: begin
            w_gnt_rd   = pipe_rd;
            w_gnt_data = pipe_data;
         end
         GNT_MDU: begin
            w_gnt_rd   = w_head_rd;
            w_gnt_data = w_head_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve <= '0;
      end else if ((w_gnt == GNT_PIPE) && w_head_live) begin
         if (r_starve != STV_W'(STARVE_LIMIT)) r_starve <= r_starve + STV_W'(1);
      end else if ((w_gnt == GNT_MDU) || !w_head_live) begin
         r_starve <= '0;
      end
   end

   // Writes to r0 complete their handshake but never assert the enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= (w_gnt != GNT_NONE) && (w_gnt_rd != '0);
         if (w_gnt != GNT_NONE) begin
            r_waddr <= w_gnt_rd;
            r_wdata <= w_gnt_data;
         end
      end
   end

   assign rf_we    = r_we;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;
   assign pend_cnt = w_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   logic        clk;
   logic        reset;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        pipe_ready;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [1:0]  pend_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   wb_port_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .pipe_valid (pipe_valid),
      .pipe_rd    (pipe_rd),
      .pipe_data  (pipe_data),
      .pipe_ready (pipe_ready),
      .mdu_valid  (mdu_valid),
      .mdu_rd     (mdu_rd),
      .mdu_data   (mdu_data),
      .mdu_ready  (mdu_ready),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .pend_cnt   (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
      pipe_valid = v;
      pipe_rd    = rd;
      pipe_data  = d;
   endtask

   task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      mdu_valid = v;
      mdu_rd    = rd;
      mdu_data  = d;
   endtask

   task automatic idle(input int n);
      set_pipe(1'b0, 5'd0, 32'h0);
      set_mdu(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_pipe(1'b0, 5'd0, 32'h0);
      set_mdu(1'b0, 5'd0, 32'h0);
      #2 reset = 1'b0;
      #1;
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %0h expected 0", rf_we); end
      n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0h expected 0", rf_waddr); end
      n_checks++; if (rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_rf_wdata: got %0h expected 0", rf_wdata); end
      n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_pend_cnt: got %0d expected 0", pend_cnt); end
      n_checks++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mdu_ready: got %0h expected 1", mdu_ready); end
      n_checks++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pipe_ready: got %0h expected 1", pipe_ready); end
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_pipe_only();
      set_pipe(1'b1, 5'd5, 32'h1234);
      #1;
      n_checks++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL pipe_only_ready: got %0h expected 1", pipe_ready); end
      step();
      n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL pipe_only_we: got %0h expected 1", rf_we); end
      n_checks++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL pipe_only_waddr: got %0d expected 5", rf_waddr); end
      n_checks++; if (rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL pipe_only_wdata: got %0h expected 1234", rf_wdata); end
      // rd==0 completes the handshake but never writes
      set_pipe(1'b1, 5'd0, 32'hFFFF);
      #1;
      n_checks++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL pipe_r0_ready: got %0h expected 1", pipe_ready); end
      step();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL pipe_r0_we: got %0h expected 0", rf_we); end
      idle(1);
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL pipe_idle_we: got %0h expected 0", rf_we); end
   endtask

   task automatic test_mdu_idle();
      set_mdu(1'b1, 5'd7, 32'hAA);
      step();
      n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL mdu_idle_cnt1: got %0d expected 1", pend_cnt); end
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mdu_idle_no_early_write: got %0h expected 0", rf_we); end
      // push rd8 while rd7 pops: count holds, order kept
      set_mdu(1'b1, 5'd8, 32'hBB);
      step();
      n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL mdu_pushpop_cnt: got %0d expected 1", pend_cnt); end
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hAA) begin n_fail++; $display("FAIL mdu_idle_write7: got we=%0h addr=%0d data=%0h expected we=1 addr=7 data=aa", rf_we, rf_waddr, rf_wdata); end
      set_mdu(1'b0, 5'd0, 32'h0);
      step();
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'hBB) begin n_fail++; $display("FAIL mdu_idle_write8: got we=%0h addr=%0d data=%0h expected we=1 addr=8 data=bb", rf_we, rf_waddr, rf_wdata); end
      n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL mdu_idle_cnt0: got %0d expected 0", pend_cnt); end
      idle(1);
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mdu_idle_quiet: got %0h expected 0", rf_we); end
   endtask

   task automatic test_starvation();
      set_mdu(1'b1, 5'd9, 32'h99);
      step();
      set_mdu(1'b0, 5'd0, 32'h0);
      n_checks++; if (pend_cnt !== 2'd1) begin n_fail++; $display("FAIL starve_queued: got %0d expected 1", pend_cnt); end
      for (int i = 1; i <= 4; i++) begin
         set_pipe(1'b1, 5'(i), 32'(32'h100 + i));
         #1;
         n_checks++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready_%0d: got %0h expected 1", i, pipe_ready); end
         step();
         n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i)) begin n_fail++; $display("FAIL starve_pipe_%0d: got we=%0h addr=%0d expected we=1 addr=%0d", i, rf_we, rf_waddr, i); end
      end
      set_pipe(1'b1, 5'd5, 32'h105);
      #1;
      n_checks++; if (pipe_ready !== 1'b0) begin n_fail++; $display("FAIL starve_force_ready: got %0h expected 0", pipe_ready); end
      step();
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin n_fail++; $display("FAIL starve_force_write: got we=%0h addr=%0d data=%0h expected we=1 addr=9 data=99", rf_we, rf_waddr, rf_wdata); end
      n_checks++; if (pend_cnt !== 2'd0) begin n_fail++; $display("FAIL starve_cnt0: got %0d expected 0", pend_cnt); end
      n_checks++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready_after: got %0h expected 1", pipe_ready); end
      step();
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h105) begin n_fail++; $display("FAIL starve_held_write: got we=%0h addr=%0d data=%0h expected we=1 addr=5 data=105", rf_we, rf_waddr, rf_wdata); end
      set_pipe(1'b1, 5'd6, 32'h106);
      step();
      n_checks++; if (rf_waddr !== 5'd6) begin n_fail++; $display("FAIL starve_pipe_6: got %0d expected 6", rf_waddr); end
      idle(1);
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL starve_quiet: got %0h expected 0", rf_we); end
   endtask

   task automatic test_full_buffer();
      set_pipe(1'b1, 5'd10, 32'h10A);
      set_mdu(1'b1, 5'd20, 32'h200);
      step();
      n_checks++; if (pend_cnt !== 2'd1 || rf_waddr !== 5'd10) begin n_fail++; $display("FAIL full_c0: got cnt=%0d addr=%0d expected cnt=1 addr=10", pend_cnt, rf_waddr); end
      set_pipe(1'b1, 5'd11, 32'h10B);
      set_mdu(1'b1, 5'd21, 32'h210);
      #1;
      n_checks++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_c1: got %0h expected 1", mdu_ready); end
      step();
      n_checks++; if (pend_cnt !== 2'd2) begin n_fail++; $display("FAIL full_cnt2: got %0d expected 2", pend_cnt); end
      n_checks++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL full_not_ready: got %0h expected 0", mdu_ready); end
      set_mdu(1'b1, 5'd22, 32'h220);
      for (int i = 12; i <= 14; i++) begin
         set_pipe(1'b1, 5'(i), 32'(32'h100 + i));
         step();
         n_checks++; if (pend_cnt !== 2'd2 || rf_waddr !== 5'(i)) begin n_fail++; $display("FAIL full_hold_%0d: got cnt=%0d addr=%0d expected cnt=2 addr=%0d", i, pend_cnt, rf_waddr, i); end
      end
      set_pipe(1'b1, 5'd15, 32'h10F);
      #1;
      n_checks++; if (pipe_ready !== 1'b0 || mdu_ready !== 1'b0) begin n_fail++; $display("FAIL full_force: got pipe_ready=%0h mdu_ready=%0h expected 0 0", pipe_ready, mdu_ready); end
      step();
      n_checks++; if (rf_waddr !== 5'd20 || rf_wdata !== 32'h200 || pend_cnt !== 2'd1) begin n_fail++; $display("FAIL full_pop20: got addr=%0d data=%0h cnt=%0d expected 20 200 1", rf_waddr, rf_wdata, pend_cnt); end
      n_checks++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_again: got %0h expected 1", mdu_ready); end
      step();
      n_checks++; if (rf_waddr !== 5'd15 || pend_cnt !== 2'd2) begin n_fail++; $display("FAIL full_push22: got addr=%0d cnt=%0d expected 15 2", rf_waddr, pend_cnt); end
      idle(1);
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd21 || rf_wdata !== 32'h210 || pend_cnt !== 2'd1) begin n_fail++; $display("FAIL full_pop21: got we=%0h addr=%0d data=%0h cnt=%0d expected 1 21 210 1", rf_we, rf_waddr, rf_wdata, pend_cnt); end
      step();
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd22 || rf_wdata !== 32'h220 || pend_cnt !== 2'd0) begin n_fail++; $display("FAIL full_pop22: got we=%0h addr=%0d data=%0h cnt=%0d expected 1 22 220 0", rf_we, rf_waddr, rf_wdata, pend_cnt); end
      step();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL full_quiet: got %0h expected 0", rf_we); end
   endtask

   task automatic test_waw_kill();
      // buffered entry killed by a younger pipe write
      set_mdu(1'b1, 5'd3, 32'h33);
      set_pipe(1'b1, 5'd1, 32'h11);
      step();
      n_checks++; if (rf_waddr !== 5'd1 || pend_cnt !== 2'd1) begin n_fail++; $display("FAIL waw_queue: got addr=%0d cnt=%0d expected 1 1", rf_waddr, pend_cnt); end
      set_mdu(1'b0, 5'd0, 32'h0);
      set_pipe(1'b1, 5'd3, 32'h55);
      step();
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h55) begin n_fail++; $display("FAIL waw_pipe_write: got we=%0h addr=%0d data=%0h expected 1 3 55", rf_we, rf_waddr, rf_wdata); end
      set_pipe(1'b0, 5'd0, 32'h0);
      step();
      n_checks++; if (rf_we !== 1'b0 || pend_cnt !== 2'd0) begin n_fail++; $display("FAIL waw_killed_pop: got we=%0h cnt=%0d expected 0 0", rf_we, pend_cnt); end
      step();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL waw_no_stale: got %0h expected 0", rf_we); end
      // same-cycle push stored killed; killed head leaves the port to the pipe
      set_mdu(1'b1, 5'd4, 32'h44);
      set_pipe(1'b1, 5'd4, 32'h66);
      step();
      n_checks++; if (rf_waddr !== 5'd4 || rf_wdata !== 32'h66 || pend_cnt !== 2'd1) begin n_fail++; $display("FAIL waw_same_cycle: got addr=%0d data=%0h cnt=%0d expected 4 66 1", rf_waddr, rf_wdata, pend_cnt); end
      set_mdu(1'b0, 5'd0, 32'h0);
      set_pipe(1'b1, 5'd6, 32'h77);
      #1;
      n_checks++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL waw_killed_ready: got %0h expected 1", pipe_ready); end
      step();
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h77 || pend_cnt !== 2'd0) begin n_fail++; $display("FAIL waw_killed_drain: got we=%0h addr=%0d data=%0h cnt=%0d expected 1 6 77 0", rf_we, rf_waddr, rf_wdata, pend_cnt); end
      idle(1);
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL waw_quiet: got %0h expected 0", rf_we); end
   endtask

   task automatic test_reset_mid();
      set_pipe(1'b1, 5'd10, 32'h10A);
      set_mdu(1'b1, 5'd20, 32'h200);
      step();
      set_pipe(1'b1, 5'd11, 32'h10B);
      set_mdu(1'b1, 5'd21, 32'h210);
      step();
      n_checks++; if (pend_cnt !== 2'd2 || rf_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got cnt=%0d we=%0h expected 2 1", pend_cnt, rf_we); end
      #1 reset = 1'b0;
      #1;
      n_checks++; if (rf_we !== 1'b0 || pend_cnt !== 2'd0 || rf_waddr !== 5'd0) begin n_fail++; $display("FAIL rstmid_async: got we=%0h cnt=%0d addr=%0d expected 0 0 0", rf_we, pend_cnt, rf_waddr); end
      n_checks++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_mdu_ready: got %0h expected 1", mdu_ready); end
      set_pipe(1'b0, 5'd0, 32'h0);
      set_mdu(1'b0, 5'd0, 32'h0);
      #2 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (rf_we !== 1'b0 || pend_cnt !== 2'd0) begin n_fail++; $display("FAIL rstmid_stale_%0d: got we=%0h cnt=%0d expected 0 0", i, rf_we, pend_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_pipe_only();
      test_mdu_idle();
      test_starvation();
      test_full_buffer();
      test_waw_kill();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
